// File: rtl/sonar_sched_pkg.sv
// Shared types and defaults for the sonar round-robin scheduler and its arbiter.
package sonar_sched_pkg;

  localparam int unsigned DEF_FREQ        = 50_000_000;
  localparam int unsigned DEF_GAP_CYCLES  = DEF_FREQ / 50;
  localparam int unsigned DEF_ACK_CYCLES  = 16;
  localparam int unsigned DEF_DONE_CYCLES = DEF_FREQ / 40;

  // Channel index width; enough for up to 8 channels.
  localparam int CH_W = 3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_START     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_CAPTURE   = 3'd5,
    S_GAP       = 3'd6
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority search: first set mask bit strictly after
// 'last', wrapping around to index 0 (and finally 'last' itself).
module rr_pick
  import sonar_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = CH_W
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] last,
  output logic [W-1:0] next_idx,
  output logic         found
);

  logic [W-1:0] hi_idx, lo_idx;
  logic         hi_found, lo_found;

  // Scan downwards so the lowest qualifying index is the one that sticks.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (mask[j]) begin
        if (j > int'(last)) begin
          hi_idx   = W'(j);
          hi_found = 1'b1;
        end else begin
          lo_idx   = W'(j);
          lo_found = 1'b1;
        end
      end
    end
    found    = hi_found | lo_found;
    next_idx = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin trigger sequencer for an array of sonar drivers (one active at a time).
// Optional handshake watchdog: define SONAR_SCHED_WDOG_EN.
module sonar_scheduler
  import sonar_sched_pkg::*;
#(
  parameter int unsigned FREQ        = DEF_FREQ,
  parameter int          NUM_CH      = 4,
  parameter int unsigned GAP_CYCLES  = FREQ / 50,
  parameter int unsigned ACK_CYCLES  = DEF_ACK_CYCLES,
  parameter int unsigned DONE_CYCLES = FREQ / 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NUM_CH-1:0]     ch_mask,
  input  logic [NUM_CH-1:0]     valid_clr,
  output logic [NUM_CH-1:0]     measure,
  input  logic [NUM_CH-1:0]     ready_in,
  input  logic [8*NUM_CH-1:0]   distance_in,
  output logic [8*NUM_CH-1:0]   dist_out,
  output logic [NUM_CH-1:0]     valid,
  output logic                  sample_stb,
  output logic [2:0]            sample_ch,
  output logic                  busy,
  output logic [NUM_CH-1:0]     err
);

  state_t          state, state_nx;
  logic [31:0]     timer;
  logic [CH_W-1:0] cur_ch, last_ch, pick_idx;
  logic            pick_found, ready_sel, tmo, capture;

  rr_pick #(.N(NUM_CH), .W(CH_W)) u_pick (
    .mask     (ch_mask),
    .last     (last_ch),
    .next_idx (pick_idx),
    .found    (pick_found)
  );

  // Only the channel in flight is observed.
  always_comb begin
    ready_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (cur_ch == CH_W'(i)) ready_sel = ready_in[i];
  end

  assign tmo     = (timer <= 32'd1);
  assign capture = (state == S_CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (enable && (ch_mask != '0)) state_nx = S_SELECT;
      S_SELECT:    state_nx = pick_found ? S_START : S_IDLE;
      S_START:     state_nx = S_WAIT_ACK;
`ifdef SONAR_SCHED_WDOG_EN
      S_WAIT_ACK:  if (!ready_sel) state_nx = S_WAIT_DONE;
                   else if (tmo)   state_nx = S_GAP;
      S_WAIT_DONE: if (ready_sel)  state_nx = S_CAPTURE;
                   else if (tmo)   state_nx = S_GAP;
`else
      S_WAIT_ACK:  if (!ready_sel) state_nx = S_WAIT_DONE;
      S_WAIT_DONE: if (ready_sel)  state_nx = S_CAPTURE;
`endif
      S_CAPTURE:   state_nx = S_GAP;
      S_GAP:       if (tmo) state_nx = enable ? S_SELECT : S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    measure = '0;
    for (int i = 0; i < NUM_CH; i++)
      measure[i] = (state == S_START) && (cur_ch == CH_W'(i));
    busy = (state != S_IDLE);
  end

  // Timer: GAP always; ACK/DONE only when the watchdog is built in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else begin
      case (state)
`ifdef SONAR_SCHED_WDOG_EN
        S_START:     timer <= ACK_CYCLES;
        S_WAIT_ACK:  if (!ready_sel) timer <= DONE_CYCLES;
                     else if (tmo)   timer <= GAP_CYCLES;
                     else            timer <= timer - 32'd1;
        S_WAIT_DONE: if (!ready_sel && tmo) timer <= GAP_CYCLES;
                     else if (!ready_sel)   timer <= timer - 32'd1;
`endif
        S_CAPTURE:   timer <= GAP_CYCLES;
        S_GAP:       if (!tmo) timer <= timer - 32'd1;
        default:     timer <= timer;
      endcase
    end
  end

  // last_ch advances on every entry into GAP so a timed-out channel is skipped next round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch     <= '0;
      last_ch    <= CH_W'(NUM_CH - 1);
      sample_stb <= 1'b0;
      sample_ch  <= '0;
      dist_out   <= '0;
      valid      <= '0;
    end else begin
      if (state == S_SELECT && pick_found) cur_ch <= pick_idx;
      if (state_nx == S_GAP && state != S_GAP) last_ch <= cur_ch;
      sample_stb <= capture;
      if (capture) sample_ch <= cur_ch;
      for (int i = 0; i < NUM_CH; i++) begin
        if (capture && cur_ch == CH_W'(i)) begin
          dist_out[8*i +: 8] <= distance_in[8*i +: 8];
          valid[i]           <= 1'b1;
        end else if (valid_clr[i]) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef SONAR_SCHED_WDOG_EN
  logic wdog_hit;
  assign wdog_hit = ((state == S_WAIT_ACK)  &&  ready_sel && tmo) ||
                    ((state == S_WAIT_DONE) && !ready_sel && tmo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wdog_hit && cur_ch == CH_W'(i)) err[i] <= 1'b1;
        else if (valid_clr[i])              err[i] <= 1'b0;
      end
    end
  end
`else
  assign err = '0;
`endif

endmodule
